// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, bit shifting on device clock edges, ACK check.
// tx_active lets the companion receiver ignore the bus while a command is on the wire.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int REQ_CYCLES     = 100,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       tx_active,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int MAX_A = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
    localparam int MAX_P = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int CW    = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] REQ_LAST = CW'(REQ_CYCLES - 1);
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, WAIT_IDLE} state_t;

    state_t state, next_state;

    logic          clk_meta, clk_sync, clk_prev, fall_q;
    logic          dat_meta, dat_sync;
    logic [7:0]    sh;
    logic          par;
    logic [CW-1:0] phase_cnt;
    logic [CW-1:0] to_cnt;
    logic [3:0]    bitcnt;
    logic          dat_drive;
    logic          inh_done, req_done, timeout, ack_edge;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + CW'(1);
    endfunction

    assign inh_done = (phase_cnt == INH_LAST);
    assign req_done = (phase_cnt == REQ_LAST);
    assign timeout  = (to_cnt >= TO_LIMIT);
    assign ack_edge = fall_q && (bitcnt == 4'd10);

    // Synchronisers idle high so reset never fakes a falling edge on an idle bus
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            clk_prev <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
            fall_q   <= 1'b0;
        end else begin
            clk_meta <= ps2_clk_in;
            clk_sync <= clk_meta;
            clk_prev <= clk_sync;
            dat_meta <= ps2_dat_in;
            dat_sync <= dat_meta;
            fall_q   <= clk_prev & ~clk_sync;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:      if (cmd_valid) next_state = INHIBIT;
            INHIBIT:   if (inh_done) next_state = REQ;
            REQ:       if (req_done) next_state = SEND;
            SEND: begin
                if (timeout) begin
                    next_state = IDLE;
                end else if (ack_edge) begin
                    next_state = dat_sync ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (timeout || (clk_sync && dat_sync)) next_state = IDLE;
            end
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sh        <= '0;
            par       <= 1'b0;
            phase_cnt <= '0;
            to_cnt    <= '0;
            bitcnt    <= '0;
            dat_drive <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        sh  <= cmd_data;
                        par <= ~^cmd_data;
                    end
                    phase_cnt <= '0;
                    to_cnt    <= '0;
                    bitcnt    <= '0;
                    dat_drive <= 1'b0;
                end
                INHIBIT: begin
                    phase_cnt <= inh_done ? '0 : sat_inc(phase_cnt);
                end
                REQ: begin
                    if (req_done) begin
                        phase_cnt <= '0;
                        to_cnt    <= '0;
                        bitcnt    <= '0;
                        dat_drive <= 1'b1;
                    end else begin
                        phase_cnt <= sat_inc(phase_cnt);
                    end
                end
                SEND: begin
                    to_cnt <= sat_inc(to_cnt);
                    if (fall_q) begin
                        if (bitcnt != 4'hF) bitcnt <= bitcnt + 4'd1;
                        if (bitcnt < 4'd8) begin
                            dat_drive <= ~sh[bitcnt[2:0]];
                        end else if (bitcnt == 4'd8) begin
                            dat_drive <= ~par;
                        end else begin
                            dat_drive <= 1'b0;
                        end
                    end
                end
                WAIT_IDLE: begin
                    to_cnt    <= sat_inc(to_cnt);
                    dat_drive <= 1'b0;
                end
                default: begin
                    phase_cnt <= '0;
                    to_cnt    <= '0;
                end
            endcase
        end
    end

    // Pulses are decoded from the final cycle of a frame so cmd_ready rises the cycle after
    always_comb begin
        cmd_ready  = (state == IDLE);
        tx_active  = (state != IDLE);
        ps2_clk_oe = (state == INHIBIT) || (state == REQ);
        ps2_dat_oe = (state == REQ) || ((state == SEND) && dat_drive && !timeout);
        tx_done    = (state == WAIT_IDLE) && !timeout && clk_sync && dat_sync;
        tx_error   = (((state == SEND) || (state == WAIT_IDLE)) && timeout) ||
                     ((state == SEND) && !timeout && ack_edge && dat_sync);
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the host, and a
// scoreboard pairs every tx_done/tx_error pulse with the command that caused it.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int REQ  = 4;
    localparam int TO   = 5000;
    localparam int HALF = 20;

    typedef struct {
        logic [7:0] data;
        bit         expect_done;
        bit         check_wire;
        int         expect_cycles;
    } exp_t;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       ps2_clk_oe, ps2_dat_oe, tx_active, tx_done, tx_error;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       ps2_clk_line, ps2_dat_line;

    exp_t       exp_q[$];
    exp_t       e;
    int         checks = 0;
    int         passed = 0;
    int         cyc = 0;
    int         model_done = 0, model_err = 0, seen_done = 0, seen_err = 0;
    int         send_start = 0, last_pulse_cyc = -10;
    int         inh_len = 0, req_len = 0;
    logic       prev_clk_oe = 1'b0;
    bit         after_pulse = 1'b0;
    logic [9:0] cap_bits = '0;

    // Open-drain bus: either side pulling low wins
    assign ps2_clk_line = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_line = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .REQ_CYCLES    (REQ),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .cmd_data  (cmd_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .ps2_clk_in(ps2_clk_line),
        .ps2_dat_in(ps2_dat_line),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .tx_active (tx_active),
        .tx_done   (tx_done),
        .tx_error  (tx_error)
    );

    always #10 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_bit(input string name, input logic actual, input logic expected);
        checks++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: actual=%b expected=%b", name, actual, expected);
    endtask

    task automatic check_int(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passed++;
        else $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Offers a command and, once accepted, records what the scoreboard should later see
    task automatic apply_stimulus(input logic [7:0] d, input bit expect_done, input bit check_wire,
                                  input int expect_cycles, input bit expect_b2b);
        int w = 0;
        cmd_data  = d;
        cmd_valid = 1'b1;
        while (!cmd_ready && w < 6000) begin
            tick(1);
            w++;
        end
        if (!cmd_ready) begin
            check_bit("accept_wait", 1'b0, 1'b1);
            cmd_valid = 1'b0;
            return;
        end
        if (expect_b2b) check_int("b2b_ready_gap", cyc - last_pulse_cyc, 1);
        tick(1);
        cmd_valid = 1'b0;
        exp_q.push_back('{d, expect_done, check_wire, expect_cycles});
        if (expect_done) model_done++;
        else model_err++;
    endtask

    // Device side: wait for request-to-send, generate 11 clocks, sample on rising edges
    task automatic device_frame(input bit give_ack, input int abort_at);
        int w = 0;
        while (!(tx_active && !ps2_clk_oe && ps2_clk_line && !ps2_dat_line) && w < 3000) begin
            tick(1);
            w++;
        end
        if (w >= 3000) begin
            check_bit("rts_seen", 1'b0, 1'b1);
            return;
        end
        tick(HALF);
        for (int i = 0; i < 11; i++) begin
            if (i == abort_at) begin
                check_bit("pre_reset_dat_oe", ps2_dat_oe, 1'b1);
                resetn = 1'b0;
                #1;
                check_bit("reset_clk_oe", ps2_clk_oe, 1'b0);
                check_bit("reset_dat_oe", ps2_dat_oe, 1'b0);
                check_bit("reset_tx_active", tx_active, 1'b0);
                foreach (exp_q[j]) begin
                    if (exp_q[j].expect_done) model_done--;
                    else model_err--;
                end
                exp_q.delete();
                dev_clk_low = 1'b0;
                dev_dat_low = 1'b0;
                tick(3);
                resetn = 1'b1;
                tick(2);
                return;
            end
            dev_clk_low = 1'b1;
            tick(HALF);
            dev_clk_low = 1'b0;
            if (i < 10) cap_bits[i] = ps2_dat_line;
            if (i == 9 && give_ack) dev_dat_low = 1'b1;
            if (i == 10) dev_dat_low = 1'b0;
            tick(HALF);
        end
    endtask

    // Monitor: request-to-send phase lengths and scoreboard matching of completion pulses
    always @(negedge clock) begin
        if (!resetn) begin
            after_pulse = 1'b0;
            inh_len     = 0;
            req_len     = 0;
            prev_clk_oe = 1'b0;
        end else begin
            if (ps2_clk_oe && !ps2_dat_oe) inh_len++;
            if (ps2_clk_oe && ps2_dat_oe) req_len++;
            if (prev_clk_oe && !ps2_clk_oe && tx_active) begin
                check_int("inhibit_len", inh_len, INH);
                check_int("req_len", req_len, REQ);
                send_start = cyc;
                inh_len    = 0;
                req_len    = 0;
            end
            prev_clk_oe = ps2_clk_oe;
            if (after_pulse) begin
                check_bit("pulse_width", tx_done | tx_error, 1'b0);
                check_bit("ready_after_pulse", cmd_ready, 1'b1);
                after_pulse = 1'b0;
            end
            if (tx_done || tx_error) begin
                check_bit("pulse_exclusive", tx_done & tx_error, 1'b0);
                check_bit("ready_low_in_pulse", cmd_ready, 1'b0);
                last_pulse_cyc = cyc;
                after_pulse    = 1'b1;
                if (tx_done) seen_done++;
                if (tx_error) seen_err++;
                if (exp_q.size() == 0) begin
                    check_bit("expected_frame_pending", 1'b0, 1'b1);
                end else begin
                    e = exp_q.pop_front();
                    check_bit("outcome_done", tx_done, e.expect_done);
                    if (e.check_wire) begin
                        check_int("wire_data", int'(cap_bits[7:0]), int'(e.data));
                        check_bit("wire_parity", cap_bits[8], ($countones(e.data) % 2) == 0);
                        check_bit("wire_stop", cap_bits[9], 1'b1);
                    end
                    if (e.expect_cycles > 0) check_int("timeout_latency", cyc - send_start, e.expect_cycles);
                end
            end
        end
    end

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] d;
        bit         ack;
        $display("[TB] starting ps2_host_tx bench");
        resetn = 1'b0;
        tick(3);
        check_bit("reset_cmd_ready", cmd_ready, 1'b1);
        check_bit("reset_clk_oe0", ps2_clk_oe, 1'b0);
        check_bit("reset_dat_oe0", ps2_dat_oe, 1'b0);
        check_bit("reset_active", tx_active, 1'b0);
        check_bit("reset_done", tx_done, 1'b0);
        check_bit("reset_error", tx_error, 1'b0);
        resetn = 1'b1;
        tick(3);

        fork
            device_frame(1'b1, 99);
            apply_stimulus(8'hED, 1'b1, 1'b1, 0, 1'b0);
        join
        tick(10);

        fork
            device_frame(1'b1, 99);
            begin
                apply_stimulus(8'h00, 1'b1, 1'b1, 0, 1'b0);
                tick(5);
                apply_stimulus(8'h01, 1'b1, 1'b1, 0, 1'b1);
            end
        join
        device_frame(1'b1, 99);
        tick(10);

        fork
            device_frame(1'b0, 99);
            apply_stimulus(8'hA7, 1'b0, 1'b1, 0, 1'b0);
        join
        tick(10);
        check_bit("noack_clk_oe", ps2_clk_oe, 1'b0);
        check_bit("noack_dat_oe", ps2_dat_oe, 1'b0);

        apply_stimulus(8'h3C, 1'b0, 1'b0, TO, 1'b0);
        tick(INH + REQ + TO + 20);
        check_bit("timeout_clk_oe", ps2_clk_oe, 1'b0);
        check_bit("timeout_dat_oe", ps2_dat_oe, 1'b0);
        check_bit("timeout_idle", tx_active, 1'b0);

        // 0x55 has bit 3 clear, so data is actively driven when reset hits
        fork
            device_frame(1'b1, 4);
            apply_stimulus(8'h55, 1'b1, 1'b1, 0, 1'b0);
        join
        fork
            device_frame(1'b1, 99);
            apply_stimulus(8'hF4, 1'b1, 1'b1, 0, 1'b0);
        join
        tick(10);

        fork
            device_frame(1'b1, 99);
            begin
                apply_stimulus(8'h3C, 1'b1, 1'b1, 0, 1'b0);
                tick(5);
                check_bit("ready_in_inhibit", cmd_ready, 1'b0);
                cmd_data  = 8'hFF;
                cmd_valid = 1'b1;
                tick(1);
                cmd_valid = 1'b0;
            end
        join
        tick(60);
        check_bit("no_queued_frame", tx_active, 1'b0);

        for (int n = 0; n < 6; n++) begin
            d   = 8'($urandom_range(0, 255));
            ack = ($urandom_range(0, 3) != 0);
            fork
                device_frame(ack, 99);
                apply_stimulus(d, ack, 1'b1, 0, 1'b0);
            join
            tick(10);
        end

        tick(5);
        check_int("done_count", seen_done, model_done);
        check_int("error_count", seen_err, model_err);
        check_int("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
